prog_delay_sweep_ctrl: RTL
==========================

// Module: prog_delay_sweep_ctrl
// PURPOSE
//  Sequences the programmable delay line through a sweep of delay_value settings.
//  Steps delay_value from a start to a stop value in fixed increments and holds each point
//  for a programmed dwell time, optionally looping.
//  Applies a new value only while the 400 MHz delay counter is idle.
//  Sits in the clk_100mhz domain between the UART byte regmap (config/go/abort) and the delay datapath.
// PARAMETERS
//  DW      16  width of delay value, start/stop/step and point_count
//  DWELLW  24  width of dwell counter (clk_100mhz cycles per point)
// PORTS
//  clk_100mhz       input   1       system clock, 100 MHz
//  rst_n_sync       input   1       reset, asynchronous, active-low
//  cfg_start        input   DW      first delay value of sweep
//  cfg_stop         input   DW      last allowed delay value (inclusive)
//  cfg_step         input   DW      increment per point; 0 = single point
//  cfg_dwell        input   DWELLW  cycles to hold each point; 0 treated as 1
//  cfg_loop         input   1       1 = restart at cfg_start after last point
//  go               input   1       1-cycle pulse, start sweep
//  abort            input   1       1-cycle pulse, stop sweep
//  path_idle        input   1       delay counter idle, already synchronized to clk_100mhz
//  delay_value      output  DW      value driven to the delay datapath
//  delay_update     output  1       1-cycle pulse, the cycle delay_value changes
//  busy             output  1       sweep in progress
//  done             output  1       sticky; set on normal completion, cleared by next accepted go
//  point_count      output  DW      points applied since last go (wraps at 2^DW)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latched config 0.
//  States: IDLE, WAIT_IDLE, DWELL, STEP.
//  IDLE:
//   - go=1 and abort=0: latch cfg_* into shadow regs; target <= cfg_start; point_count <= 0;
//     done <= 0; busy <= 1; -> WAIT_IDLE.
//   - Shadow regs are used for the whole sweep; cfg_* changes mid-sweep are ignored.
//  WAIT_IDLE:
//   - Stays until path_idle=1.
//   - In the cycle path_idle=1 is sampled: delay_value <= target, delay_update <= 1 (next cycle only),
//     point_count += 1, dwell_cnt <= max(dwell,1)-1, -> DWELL.
//  DWELL:
//   - dwell_cnt decrements each cycle; at 0 -> STEP.
//   - Each point is held dwell cycles (min 1) after the update cycle.
//  STEP:
//   - nxt = {1'b0,target} + step, DW+1 bits.
//   - Point is last if step==0, or nxt[DW]==1 (overflow), or nxt[DW-1:0] > stop.
//   - Not last: target <= nxt; -> WAIT_IDLE.
//   - Last, loop=1: target <= start; -> WAIT_IDLE.
//   - Last, loop=0: busy <= 0, done <= 1; -> IDLE.
//   - STEP is exactly 1 cycle.
//  start > stop: start is applied once, then the sweep ends (or repeats start if loop).
//  abort (any state except IDLE): next cycle IDLE, busy=0, done unchanged (stays 0).
//   - delay_value holds its last applied value; no delay_update.
//  abort in IDLE: no effect. go and abort in the same cycle: abort wins, go ignored.
//  go while busy: ignored.
//  Reset mid-sweep: immediate return to reset values, including delay_value=0.
//  Minimum per-point period, path_idle held 1: 1 (WAIT_IDLE) + dwell + 1 (STEP) cycles.
// TESTING
//  1. start=10, stop=30, step=10, dwell=4, loop=0, path_idle=1, go:
//     - update pulses with delay_value 10,20,30, 6 cycles apart.
//     - done=1, busy=0, point_count=3.
//  2. start=5, step=0, dwell=0, go:
//     - single update, delay_value=5, dwell treated as 1, done=1, point_count=1.
//  3. start=0xFFF0, stop=0xFFFF, step=0x20, go:
//     - one point 0xFFF0; overflow ends sweep; no update with wrapped value; done=1.
//  4. path_idle=0 for 50 cycles after go:
//     - no delay_update and delay_value unchanged until path_idle rises.
//     - update occurs the cycle after path_idle=1 is sampled.
//  5. loop=1, start=1, stop=2, step=1, then abort after 5 updates:
//     - sequence 1,2,1,2,1; busy=0 the cycle after abort.
//     - delay_value=1 holds, done=0.
//  6. Simultaneous go+abort in IDLE: busy stays 0. Then go during busy with new cfg:
//     - ignored; the sweep continues with the originally latched values.

Source files
------------

// File: rtl/prog_delay_sweep_ctrl.sv
// Steps delay_value from cfg_start toward cfg_stop in cfg_step increments.
// Each point is held for cfg_dwell cycles. A new value is applied only while the delay path is idle.
module prog_delay_sweep_ctrl #(
    parameter int DW     = 16,
    parameter int DWELLW = 24
) (
    input  logic              clk_100mhz,
    input  logic              rst_n_sync,
    input  logic [DW-1:0]     cfg_start,
    input  logic [DW-1:0]     cfg_stop,
    input  logic [DW-1:0]     cfg_step,
    input  logic [DWELLW-1:0] cfg_dwell,
    input  logic              cfg_loop,
    input  logic              go,
    input  logic              abort,
    input  logic              path_idle,
    output logic [DW-1:0]     delay_value,
    output logic              delay_update,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     point_count
);

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, DWELL, STEP} state_t;

    state_t            state, state_nxt;
    logic [DW-1:0]     sh_start, sh_stop, sh_step, target;
    logic [DWELLW-1:0] sh_dwell, dwell_cnt;
    logic              sh_loop;

    logic [DW-1:0]     sh_start_nxt, sh_stop_nxt, sh_step_nxt, target_nxt;
    logic [DWELLW-1:0] sh_dwell_nxt, dwell_cnt_nxt;
    logic              sh_loop_nxt;
    logic [DW-1:0]     delay_value_nxt, point_count_nxt;
    logic              delay_update_nxt, busy_nxt, done_nxt;

    // Extra carry bit catches a step that would wrap past the top of the range.
    logic [DW:0]       nxt_sum;
    logic              is_last;
    logic [DWELLW-1:0] dwell_load;

    assign nxt_sum    = {1'b0, target} + {1'b0, sh_step};
    assign is_last    = (sh_step == '0) || nxt_sum[DW] || (nxt_sum[DW-1:0] > sh_stop);
    assign dwell_load = (sh_dwell == '0) ? '0 : sh_dwell - DWELLW'(1);

    always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state        <= IDLE;
            sh_start     <= '0;
            sh_stop      <= '0;
            sh_step      <= '0;
            sh_dwell     <= '0;
            sh_loop      <= 1'b0;
            target       <= '0;
            dwell_cnt    <= '0;
            delay_value  <= '0;
            delay_update <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            point_count  <= '0;
        end else begin
            state        <= state_nxt;
            sh_start     <= sh_start_nxt;
            sh_stop      <= sh_stop_nxt;
            sh_step      <= sh_step_nxt;
            sh_dwell     <= sh_dwell_nxt;
            sh_loop      <= sh_loop_nxt;
            target       <= target_nxt;
            dwell_cnt    <= dwell_cnt_nxt;
            delay_value  <= delay_value_nxt;
            delay_update <= delay_update_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            point_count  <= point_count_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        sh_start_nxt     = sh_start;
        sh_stop_nxt      = sh_stop;
        sh_step_nxt      = sh_step;
        sh_dwell_nxt     = sh_dwell;
        sh_loop_nxt      = sh_loop;
        target_nxt       = target;
        dwell_cnt_nxt    = dwell_cnt;
        delay_value_nxt  = delay_value;
        delay_update_nxt = 1'b0;
        busy_nxt         = busy;
        done_nxt         = done;
        point_count_nxt  = point_count;

        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go && !abort) begin
                        sh_start_nxt    = cfg_start;
                        sh_stop_nxt     = cfg_stop;
                        sh_step_nxt     = cfg_step;
                        sh_dwell_nxt    = cfg_dwell;
                        sh_loop_nxt     = cfg_loop;
                        target_nxt      = cfg_start;
                        point_count_nxt = '0;
                        done_nxt        = 1'b0;
                        busy_nxt        = 1'b1;
                        state_nxt       = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (path_idle) begin
                        delay_value_nxt  = target;
                        delay_update_nxt = 1'b1;
                        point_count_nxt  = point_count + DW'(1);
                        dwell_cnt_nxt    = dwell_load;
                        state_nxt        = DWELL;
                    end
                end
                DWELL: begin
                    if (dwell_cnt == '0) state_nxt = STEP;
                    else                 dwell_cnt_nxt = dwell_cnt - DWELLW'(1);
                end
                STEP: begin
                    if (!is_last) begin
                        target_nxt = nxt_sum[DW-1:0];
                        state_nxt  = WAIT_IDLE;
                    end else if (sh_loop) begin
                        target_nxt = sh_start;
                        state_nxt  = WAIT_IDLE;
                    end else begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
